// File: rtl/memory_port_arbiter.sv
// Memory port arbiter: shares one memory port between an instruction-fetch
// requester and a data requester, one transaction outstanding at a time.
// Data requests win unless fetch has been starved for STARVE_LIMIT grants.
module memory_port_arbiter #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                fetch_request_valid,
    output logic                fetch_request_ready,
    input  logic [XLEN-1:0]     fetch_request_PC,

    output logic                fetch_response_valid,
    input  logic                fetch_response_ready,
    output logic [XLEN-1:0]     fetch_response_instruction,
    output logic [XLEN-1:0]     fetch_response_PC,

    input  logic                d_read,
    input  logic                d_write,
    input  logic [XLEN/8-1:0]   d_byte_en,
    input  logic [XLEN-1:0]     d_address,
    input  logic [XLEN-1:0]     d_data,
    output logic                d_ready,

    output logic                d_valid,
    output logic [XLEN-1:0]     d_data_in,
    output logic [XLEN-1:0]     d_address_in,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_write,
    output logic [XLEN/8-1:0]   mem_req_byte_en,
    output logic [XLEN-1:0]     mem_req_address,
    output logic [XLEN-1:0]     mem_req_data,

    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_resp_data,
    input  logic [XLEN-1:0]     mem_resp_address,

    output logic                err
);

    localparam int unsigned BE_W       = XLEN / 8;
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Captured request for the single outstanding transaction
    typedef struct packed {
        logic              fetch;
        logic              write;
        logic [BE_W-1:0]   byte_en;
        logic [XLEN-1:0]   address;
        logic [XLEN-1:0]   data;
    } txn_t;

    state_t            state_q, state_d;
    txn_t              txn_q, txn_d;
    logic [3:0]        starve_q, starve_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
    logic              data_pending;
    logic              fetch_wins;

    // State and captured-transaction registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            txn_q        <= '0;
            starve_q     <= '0;
            err_q        <= 1'b0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            txn_q        <= txn_d;
            starve_q     <= starve_d;
            err_q        <= err_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Arbitration, next state and response steering
    always_comb begin
        state_d      = state_q;
        txn_d        = txn_q;
        starve_d     = starve_q;
        err_d        = err_q;
        hold_instr_d = hold_instr_q;

        fetch_request_ready        = 1'b0;
        d_ready                    = 1'b0;
        d_valid                    = 1'b0;
        d_data_in                  = '0;
        d_address_in               = '0;
        fetch_response_valid       = 1'b0;
        fetch_response_instruction = '0;
        fetch_response_PC          = '0;

        data_pending = d_read | d_write;
        fetch_wins   = fetch_request_valid &&
                       (!data_pending || (starve_q == STARVE_MAX));

        case (state_q)
            IDLE: begin
                if (mem_resp_valid || (d_read && d_write)) begin
                    err_d = 1'b1;
                end
                // Grants are masked while reset is held so outputs stay quiet
                if (reset && fetch_wins) begin
                    fetch_request_ready = 1'b1;
                    txn_d.fetch         = 1'b1;
                    txn_d.write         = 1'b0;
                    txn_d.byte_en       = '1;
                    txn_d.address       = fetch_request_PC;
                    txn_d.data          = '0;
                    starve_d            = '0;
                    state_d             = REQ;
                end else if (reset && data_pending) begin
                    d_ready       = 1'b1;
                    txn_d.fetch   = 1'b0;
                    txn_d.write   = d_write;
                    txn_d.byte_en = d_byte_en;
                    txn_d.address = d_address;
                    txn_d.data    = d_data;
                    if (fetch_request_valid && (starve_q < STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_resp_valid) begin
                    err_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (txn_q.fetch) begin
                        fetch_response_valid       = 1'b1;
                        fetch_response_instruction = mem_resp_data;
                        fetch_response_PC          = txn_q.address;
                        if (fetch_response_ready) begin
                            state_d = IDLE;
                        end else begin
                            hold_instr_d = mem_resp_data;
                            state_d      = HOLD;
                        end
                    end else begin
                        d_valid      = 1'b1;
                        d_data_in    = mem_resp_data;
                        d_address_in = mem_resp_address;
                        state_d      = IDLE;
                    end
                end
            end
            HOLD: begin
                if (mem_resp_valid) begin
                    err_d = 1'b1;
                end
                fetch_response_valid       = 1'b1;
                fetch_response_instruction = hold_instr_q;
                fetch_response_PC          = txn_q.address;
                if (fetch_response_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory request mirrors the captured transaction while in REQ
    assign mem_req_valid   = (state_q == REQ);
    assign mem_req_write   = txn_q.write;
    assign mem_req_byte_en = txn_q.byte_en;
    assign mem_req_address = txn_q.address;
    assign mem_req_data    = txn_q.data;
    assign err             = err_q;

endmodule
